// File: rtl/data_mem_bundle_ctrl_pkg.sv
// Shared types for the two-port data memory bundle controller.
// Holds defaults, FSM encoding, the memory slot struct and the hazard rule.
package data_mem_bundle_ctrl_pkg;

  localparam int DEPTH_DFLT = 140001;
  localparam int TAG_W      = 6;
  localparam int CNT_W_DFLT = 32;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SPLIT = 1'b1;

  typedef struct packed {
    logic             en;
    logic             we;
    logic [31:0]      addr;
    logic [31:0]      wdata;
    logic [TAG_W-1:0] tag;
  } mem_slot_t;

  // Two loads to one address can share a cycle; anything involving a store cannot.
  function automatic logic same_addr_hazard(mem_slot_t a, mem_slot_t b);
    return a.en & b.en & (a.addr == b.addr) & (a.we | b.we);
  endfunction

endpackage

// File: rtl/data_mem_bundle_ctrl_if.sv
// MEM-stage bundle handshake: one two-slot bundle moves when in_valid & in_ready.
// master = MEM stage, slave = memory bundle controller.
interface data_mem_bundle_ctrl_if;
  import data_mem_bundle_ctrl_pkg::*;

  logic      in_valid;
  logic      in_ready;
  mem_slot_t s0;
  mem_slot_t s1;

  modport master (output in_valid, output s0, output s1, input in_ready);
  modport slave  (input in_valid, input s0, input s1, output in_ready);

endinterface

// File: rtl/data_mem_bundle_ctrl_port_drv.sv
// One memory port: range check, registered port drive, load tracking, response mux.
// Port active one cycle after issue; response valid two cycles after issue, never stalls.
module data_mem_port_drv
  import data_mem_bundle_ctrl_pkg::*;
#(
  parameter int DEPTH = DEPTH_DFLT
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             issue,
  input  mem_slot_t        slot,
  output logic             en,
  output logic             we,
  output logic [31:0]      addr,
  output logic [31:0]      di,
  input  logic [31:0]      dout,
  output logic             oob_hit,
  output logic             r_valid,
  output logic [31:0]      r_data,
  output logic [TAG_W-1:0] r_tag
);

  logic             act;
  logic             in_range;
  logic             rd_pend, rd_oob;
  logic             rsp_vld, rsp_oob;
  logic [TAG_W-1:0] rd_tag, rsp_tag;

  assign act      = issue & slot.en;
  assign in_range = slot.addr < 32'(DEPTH);
  assign oob_hit  = act & ~in_range;

  // Out-of-range loads still travel down the pipe so writeback receives a zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      en      <= 1'b0;
      we      <= 1'b0;
      addr    <= '0;
      di      <= '0;
      rd_pend <= 1'b0;
      rd_oob  <= 1'b0;
      rd_tag  <= '0;
      rsp_vld <= 1'b0;
      rsp_oob <= 1'b0;
      rsp_tag <= '0;
    end else begin
      en      <= act & in_range;
      we      <= act & in_range & slot.we;
      if (act) begin
        addr <= slot.addr;
        di   <= slot.wdata;
      end
      rd_pend <= act & ~slot.we;
      rd_oob  <= ~in_range;
      rd_tag  <= slot.tag;
      rsp_vld <= rd_pend;
      rsp_oob <= rd_oob;
      rsp_tag <= rd_tag;
    end
  end

  assign r_valid = rsp_vld;
  assign r_data  = rsp_oob ? 32'h0 : dout;
  assign r_tag   = rsp_tag;

endmodule

// File: rtl/data_mem_bundle_ctrl.sv
// VLIW bundle initiator: slot 0 -> port A, slot 1 -> port B; same-address hazards split over two cycles.
// Loads return two cycles after accept (three for a split slot 1); in_ready drops only during SPLIT.
module data_mem_bundle_ctrl
  import data_mem_bundle_ctrl_pkg::*;
#(
  parameter int DEPTH = DEPTH_DFLT,
  parameter int CNT_W = CNT_W_DFLT
) (
  input  logic                   clk,
  input  logic                   rstn,
  data_mem_bundle_ctrl_if.slave  bus,
  output logic                   ena,
  output logic                   enb,
  output logic                   wea,
  output logic                   web,
  output logic [31:0]            addra,
  output logic [31:0]            addrb,
  output logic [31:0]            dia,
  output logic [31:0]            dib,
  input  logic [31:0]            doa,
  input  logic [31:0]            dob,
  output logic                   r0_valid,
  output logic                   r1_valid,
  output logic [31:0]            r0_data,
  output logic [31:0]            r1_data,
  output logic [TAG_W-1:0]       r0_tag,
  output logic [TAG_W-1:0]       r1_tag,
  output logic                   oob_err,
  output logic [CNT_W-1:0]       conflict_cnt
);

  logic [0:0] state;
  mem_slot_t  held;
  mem_slot_t  slot_b;
  logic       accept, conflict, issue_b;
  logic       oob_a, oob_b;

  assign bus.in_ready = (state == ST_IDLE);
  assign accept       = bus.in_valid & bus.in_ready;
  assign conflict     = same_addr_hazard(bus.s0, bus.s1);
  // Slot 0 is older, so it always goes first; slot 1 waits a cycle on a hazard.
  assign issue_b      = (state == ST_SPLIT) | (accept & ~conflict);
  assign slot_b       = (state == ST_SPLIT) ? held : bus.s1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= ST_IDLE;
      held         <= '0;
      conflict_cnt <= '0;
      oob_err      <= 1'b0;
    end else begin
      oob_err <= oob_err | oob_a | oob_b;
      if (state == ST_SPLIT) begin
        state <= ST_IDLE;
      end else if (accept && conflict) begin
        state <= ST_SPLIT;
        held  <= bus.s1;
        if (conflict_cnt != {CNT_W{1'b1}})
          conflict_cnt <= conflict_cnt + CNT_W'(1);
      end
    end
  end

  data_mem_port_drv #(.DEPTH(DEPTH)) u_port_a (
    .clk     (clk),
    .rstn    (rstn),
    .issue   (accept),
    .slot    (bus.s0),
    .en      (ena),
    .we      (wea),
    .addr    (addra),
    .di      (dia),
    .dout    (doa),
    .oob_hit (oob_a),
    .r_valid (r0_valid),
    .r_data  (r0_data),
    .r_tag   (r0_tag)
  );

  data_mem_port_drv #(.DEPTH(DEPTH)) u_port_b (
    .clk     (clk),
    .rstn    (rstn),
    .issue   (issue_b),
    .slot    (slot_b),
    .en      (enb),
    .we      (web),
    .addr    (addrb),
    .di      (dib),
    .dout    (dob),
    .oob_hit (oob_b),
    .r_valid (r1_valid),
    .r_data  (r1_data),
    .r_tag   (r1_tag)
  );

endmodule

// File: tb/tb_data_mem_bundle_ctrl.sv
// Bench for data_mem_bundle_ctrl: behavioural RAM, program-order reference model, response scoreboard.
module tb_data_mem_bundle_ctrl;
  import data_mem_bundle_ctrl_pkg::*;

  localparam int DEPTH = DEPTH_DFLT;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  data_mem_bundle_ctrl_if bus();

  logic             ena, enb, wea, web;
  logic [31:0]      addra, addrb, dia, dib;
  logic [31:0]      doa = 32'h0;
  logic [31:0]      dob = 32'h0;
  logic             r0_valid, r1_valid, oob_err;
  logic [31:0]      r0_data, r1_data;
  logic [TAG_W-1:0] r0_tag, r1_tag;
  logic [31:0]      conflict_cnt;

  data_mem_bundle_ctrl #(.DEPTH(DEPTH), .CNT_W(32)) dut (
    .clk(clk), .rstn(rstn), .bus(bus),
    .ena(ena), .enb(enb), .wea(wea), .web(web),
    .addra(addra), .addrb(addrb), .dia(dia), .dib(dib),
    .doa(doa), .dob(dob),
    .r0_valid(r0_valid), .r1_valid(r1_valid),
    .r0_data(r0_data), .r1_data(r1_data),
    .r0_tag(r0_tag), .r1_tag(r1_tag),
    .oob_err(oob_err), .conflict_cnt(conflict_cnt)
  );

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
    int               cyc;
  } exp_t;

  exp_t             q0[$], q1[$];
  exp_t             e0, e1;
  bit [31:0]        ram [int unsigned];
  bit [31:0]        mdl [int unsigned];
  int               checks = 0, failures = 0, cyc = 0, nresp = 0;
  bit               mdl_oob = 1'b0;
  int               mdl_conf = 0;
  logic [TAG_W-1:0] tg = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit [31:0] rd_ram(input int unsigned a);
    return ram.exists(a) ? ram[a] : 32'h0;
  endfunction

  function automatic bit [31:0] rd_mdl(input int unsigned a);
    return mdl.exists(a) ? mdl[a] : 32'h0;
  endfunction

  // Behavioural two-port RAM, read-first, one-cycle read latency.
  always @(posedge clk) begin
    if (ena) doa <= rd_ram(addra);
    if (enb) dob <= rd_ram(addrb);
    if (ena && wea) ram[addra] = dia;
    if (enb && web) ram[addrb] = dib;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rstn) begin
      if (r0_valid) begin
        checks++; nresp++;
        if (q0.size() == 0) begin
          failures++;
          $display("FAIL r0_unexpected actual tag=%0h data=%0h required=no response", r0_tag, r0_data);
        end else begin
          e0 = q0.pop_front();
          if (r0_tag !== e0.tag || r0_data !== e0.data || cyc != e0.cyc) begin
            failures++;
            $display("FAIL r0_resp actual tag=%0h data=%0h cyc=%0d required tag=%0h data=%0h cyc=%0d",
                     r0_tag, r0_data, cyc, e0.tag, e0.data, e0.cyc);
          end
        end
      end
      if (r1_valid) begin
        checks++; nresp++;
        if (q1.size() == 0) begin
          failures++;
          $display("FAIL r1_unexpected actual tag=%0h data=%0h required=no response", r1_tag, r1_data);
        end else begin
          e1 = q1.pop_front();
          if (r1_tag !== e1.tag || r1_data !== e1.data || cyc != e1.cyc) begin
            failures++;
            $display("FAIL r1_resp actual tag=%0h data=%0h cyc=%0d required tag=%0h data=%0h cyc=%0d",
                     r1_tag, r1_data, cyc, e1.tag, e1.data, e1.cyc);
          end
        end
      end
      if (ena) chk("ena_in_range", 64'(addra < DEPTH), 64'd1);
      if (enb) chk("enb_in_range", 64'(addrb < DEPTH), 64'd1);
    end
  end

  function automatic mem_slot_t mk(input logic en, input logic we, input logic [31:0] a,
                                   input logic [31:0] d, input logic [TAG_W-1:0] t);
    mem_slot_t s;
    s.en = en; s.we = we; s.addr = a; s.wdata = d; s.tag = t;
    return s;
  endfunction

  // Reference: execute slot 0 then slot 1 in program order on a flat memory.
  task automatic model_slot(input mem_slot_t s, input int rcyc, input bit port1);
    exp_t e;
    if (!s.en) return;
    if (s.addr >= DEPTH) mdl_oob = 1'b1;
    if (s.we) begin
      if (s.addr < DEPTH) mdl[s.addr] = s.wdata;
    end else begin
      e.tag  = s.tag;
      e.data = (s.addr < DEPTH) ? rd_mdl(s.addr) : 32'h0;
      e.cyc  = rcyc;
      if (port1) q1.push_back(e); else q0.push_back(e);
    end
  endtask

  task automatic model_accept(input mem_slot_t a, input mem_slot_t b, input int n);
    bit conf;
    conf = a.en && b.en && (a.addr == b.addr) && (a.we || b.we);
    if (conf) mdl_conf++;
    model_slot(a, n + 1, 1'b0);
    model_slot(b, conf ? n + 2 : n + 1, 1'b1);
  endtask

  task automatic send(input mem_slot_t a, input mem_slot_t b, output int tries);
    bit rdy;
    tries = 0;
    bus.s0 = a; bus.s1 = b; bus.in_valid = 1'b1;
    do begin
      @(negedge clk); rdy = bus.in_ready;
      @(posedge clk); #1; tries++;
    end while (!rdy && tries < 20);
    if (!rdy) begin
      checks++; failures++;
      $display("FAIL accept_timeout actual=not accepted required=accepted within 20 cycles");
    end else begin
      model_accept(a, b, cyc);
    end
  endtask

  task automatic idle();
    bus.in_valid = 1'b0; bus.s0 = '0; bus.s1 = '0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_addr();
    int r;
    r = $urandom_range(0, 15);
    if (r == 15) return 32'(DEPTH) + 32'($urandom_range(0, 3));
    if (r == 14) return 32'(DEPTH - 1);
    return 32'($urandom_range(0, 7));
  endfunction

  initial begin
    int t;
    int n0;
    mem_slot_t sa, sb;
    idle();
    #12;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_ena", 64'(ena), 64'd0);
    chk("rst_enb", 64'(enb), 64'd0);
    chk("rst_wea_web", 64'({wea, web}), 64'd0);
    chk("rst_rvalid", 64'({r0_valid, r1_valid}), 64'd0);
    chk("rst_oob", 64'(oob_err), 64'd0);
    chk("rst_cnt", 64'(conflict_cnt), 64'd0);
    chk("rst_addr", 64'({addra, addrb}), 64'd0);
    @(negedge clk); rstn = 1'b1;
    wait_cyc(1);

    ram[5] = 32'h11; mdl[5] = 32'h11;
    ram[9] = 32'h22; mdl[9] = 32'h22;
    ram[DEPTH-1] = 32'h5A5A_0001; mdl[DEPTH-1] = 32'h5A5A_0001;
    for (int i = 20; i < 48; i++) begin
      bit [31:0] v;
      v = $urandom;
      ram[i] = v; mdl[i] = v;
    end

    // Independent loads
    send(mk(1, 0, 5, 0, 6'd1), mk(1, 0, 9, 0, 6'd2), t);
    chk("indep_no_stall", 64'(t), 64'd1);
    idle();
    @(negedge clk);
    chk("indep_ready_kept", 64'(bus.in_ready), 64'd1);
    wait_cyc(3);

    // Store then load, same address
    send(mk(1, 1, 100, 32'hDEADBEEF, 6'd3), mk(1, 0, 100, 0, 6'd4), t);
    idle();
    @(negedge clk);
    chk("split_ready_low", 64'(bus.in_ready), 64'd0);
    wait_cyc(4);
    chk("conflict_cnt_1", 64'(conflict_cnt), 64'd1);

    // Store-store, then read back
    send(mk(1, 1, 7, 32'hA, 6'd5), mk(1, 1, 7, 32'hB, 6'd6), t);
    idle();
    wait_cyc(1);
    send(mk(1, 0, 7, 0, 6'd7), mk(0, 0, 0, 0, 6'd8), t);
    idle();
    wait_cyc(4);
    chk("conflict_cnt_2", 64'(conflict_cnt), 64'(mdl_conf));

    // Out of range and the last valid word
    chk("oob_before", 64'(oob_err), 64'd0);
    send(mk(1, 0, 32'(DEPTH), 0, 6'd9), mk(1, 0, 32'(DEPTH - 1), 0, 6'd10), t);
    idle();
    wait_cyc(4);
    chk("oob_set", 64'(oob_err), 64'd1);
    wait_cyc(4);
    chk("oob_sticky", 64'(oob_err), 64'd1);

    // Back-to-back stream, no bubbles
    n0 = nresp;
    for (int i = 0; i < 8; i++) begin
      send(mk(1, 0, 32'(20 + i), 0, 6'(16 + 2 * i)), mk(1, 0, 32'(36 + i), 0, 6'(17 + 2 * i)), t);
      chk("b2b_no_bubble", 64'(t), 64'd1);
    end
    idle();
    wait_cyc(5);
    chk("b2b_resp_count", 64'(nresp - n0), 64'd16);

    // Randomized bundles
    for (int i = 0; i < 60; i++) begin
      sa = mk(($urandom_range(0, 3) != 0), $urandom_range(0, 1), rnd_addr(), $urandom, tg);
      tg++;
      sb = mk(($urandom_range(0, 3) != 0), $urandom_range(0, 1), rnd_addr(), $urandom, tg);
      tg++;
      if ($urandom_range(0, 1) == 1) sb.addr = sa.addr;
      send(sa, sb, t);
      if ($urandom_range(0, 3) == 0) begin
        idle();
        wait_cyc($urandom_range(1, 2));
      end
    end
    idle();
    wait_cyc(6);
    chk("rand_conflict_cnt", 64'(conflict_cnt), 64'(mdl_conf));
    chk("rand_oob", 64'(oob_err), 64'(mdl_oob));
    chk("drain_q0", 64'(q0.size()), 64'd0);
    chk("drain_q1", 64'(q1.size()), 64'd0);

    // Reset while slot 1 waits in SPLIT
    send(mk(1, 1, 200, 32'h55, 6'd11), mk(1, 0, 200, 0, 6'd12), t);
    idle();
    #2;
    rstn = 1'b0;
    q0.delete(); q1.delete();
    mdl.delete(200);
    mdl_conf = 0; mdl_oob = 1'b0;
    #1;
    chk("mid_rst_ena", 64'(ena), 64'd0);
    chk("mid_rst_enb", 64'(enb), 64'd0);
    chk("mid_rst_cnt", 64'(conflict_cnt), 64'd0);
    chk("mid_rst_oob", 64'(oob_err), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_no_r1", 64'({r1_valid, enb}), 64'd0);
    end
    chk("post_rst_ready", 64'(bus.in_ready), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=still running required=finished");
    $fatal(1, "timeout");
  end

endmodule
